// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - scoreboard entry type, constants and parameter range checks for hazard_ctrl
package hazard_pkg;

  // Register indices are held zero-extended to REG_W_MAX so one entry type serves every REG_W.
  localparam int REG_W_MAX = 8;

  typedef logic [REG_W_MAX-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;

  typedef struct packed {
    logic     v;
    reg_idx_t rd;
    logic     ld;
  } sb_entry_t;

  localparam sb_entry_t SB_EMPTY = '{v: 1'b0, rd: REG_ZERO, ld: 1'b0};

  function automatic bit pipe_depth_ok(int depth);
    return (depth >= 2) && (depth <= 6);
  endfunction

  function automatic bit br_penalty_ok(int penalty);
    return (penalty >= 1) && (penalty <= 7);
  endfunction

  function automatic bit reg_w_ok(int width);
    return (width >= 1) && (width <= REG_W_MAX);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// rtl/hazard_match.sv - compares one scoreboard entry against the ID source operands
module hazard_match
  import hazard_pkg::*;
(
  input  logic                 valid_i,
  input  logic [REG_W_MAX-1:0] rd_i,
  input  logic [REG_W_MAX-1:0] rs_i,
  input  logic                 use_rs_i,
  input  logic [REG_W_MAX-1:0] rt_i,
  input  logic                 use_rt_i,
  output logic                 match_o
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit  = use_rs_i & (rd_i == rs_i);
  assign rt_hit  = use_rt_i & (rd_i == rt_i);
  // r0 is hardwired, so a pending write to it can never be a real dependency.
  assign match_o = valid_i & (rd_i != REG_ZERO) & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard/stall controller with destination scoreboard, branch freeze and stall counter
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int PIPE_DEPTH = 3,
  parameter int FWD_EN     = 0,
  parameter int BR_PENALTY = 2,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_wr,
  input  logic             id_is_load,
  input  logic             id_is_branch,
  output logic             if_stall,
  output logic             id_stall,
  output logic             ex_bubble,
  output logic [CNT_W-1:0] stall_cnt
);

  if (!pipe_depth_ok(PIPE_DEPTH) || !br_penalty_ok(BR_PENALTY) || !reg_w_ok(REG_W)) begin : g_bad_param
    $error("hazard_ctrl: parameter out of legal range");
  end

  localparam logic [2:0] BR_LOAD_VAL = 3'(BR_PENALTY - 1);

  sb_entry_t        sb_q [PIPE_DEPTH];
  sb_entry_t        sb_d [PIPE_DEPTH];
  logic [2:0]       br_cnt_q;
  logic [2:0]       br_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  reg_idx_t               rs_ext;
  reg_idx_t               rt_ext;
  reg_idx_t               rd_ext;
  logic [PIPE_DEPTH-1:0]  match;
  logic                   hazard;
  logic                   issue;
  logic                   br_load;

  assign rs_ext = reg_idx_t'(id_rs);
  assign rt_ext = reg_idx_t'(id_rt);
  assign rd_ext = reg_idx_t'(id_rd);

  for (genvar k = 0; k < PIPE_DEPTH; k++) begin : g_match
    hazard_match u_match (
      .valid_i  (sb_q[k].v),
      .rd_i     (sb_q[k].rd),
      .rs_i     (rs_ext),
      .use_rs_i (id_use_rs),
      .rt_i     (rt_ext),
      .use_rt_i (id_use_rt),
      .match_o  (match[k])
    );
  end

  // The WB entry never stalls: the register file writes before it reads in that cycle.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      if (FWD_EN != 0) begin
        if (k == 0) begin
          hazard = hazard | (match[k] & sb_q[k].ld);
        end
      end else if (k < PIPE_DEPTH - 1) begin
        hazard = hazard | match[k];
      end
    end
  end

  assign id_stall  = id_valid & hazard;
  assign issue     = id_valid & ~id_stall;
  assign ex_bubble = ~issue;
  assign br_load   = issue & id_is_branch;
  assign if_stall  = id_stall | br_load | (br_cnt_q != 3'd0);
  assign stall_cnt = stall_cnt_q;

  always_comb begin
    sb_d[0] = issue ? sb_entry_t'{v: id_reg_wr & (rd_ext != REG_ZERO), rd: rd_ext, ld: id_is_load}
                    : SB_EMPTY;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  // A new branch reloads the freeze rather than extending it.
  always_comb begin
    br_cnt_d = br_cnt_q;
    if (br_load) begin
      br_cnt_d = BR_LOAD_VAL;
    end else if (br_cnt_q != 3'd0) begin
      br_cnt_d = br_cnt_q - 3'd1;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (id_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sb_q        <= '{default: SB_EMPTY};
      br_cnt_q    <= 3'd0;
      stall_cnt_q <= '0;
    end else begin
      sb_q        <= sb_d;
      br_cnt_q    <= br_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (no-forwarding and load-use-forwarding builds)
module tb_hazard_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;
  localparam int BR_PEN  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_reg_wr = 1'b0, id_is_load = 1'b0, id_is_branch = 1'b0;

  logic [1:0]       if_stall_v, id_stall_v, ex_bubble_v;
  logic [CNT_W-1:0] stall_cnt_v [2];

  hazard_ctrl #(.REG_W(5), .PIPE_DEPTH(3), .FWD_EN(0), .BR_PENALTY(BR_PEN), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .if_stall(if_stall_v[0]),
    .id_stall(id_stall_v[0]), .ex_bubble(ex_bubble_v[0]), .stall_cnt(stall_cnt_v[0])
  );

  hazard_ctrl #(.REG_W(5), .PIPE_DEPTH(4), .FWD_EN(1), .BR_PENALTY(BR_PEN), .CNT_W(CNT_W)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_is_load(id_is_load), .id_is_branch(id_is_branch), .if_stall(if_stall_v[1]),
    .id_stall(id_stall_v[1]), .ex_bubble(ex_bubble_v[1]), .stall_cnt(stall_cnt_v[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: per register, the cycle its latest write issued; hazards follow from the age of that write.
  int cyc = 0;
  int last_wr [2][32];
  bit last_ld [2][32];
  int last_br [2];
  int cnt     [2];

  function automatic int depth_of(int d);
    return (d == 0) ? 3 : 4;
  endfunction

  function automatic bit src_hazard(int d, logic use_it, logic [4:0] r);
    int age;
    if (!use_it || r == 5'd0) return 1'b0;
    age = cyc - last_wr[d][r];
    if (d == 1) return (age == 1) && last_ld[d][r];
    return (age >= 1) && (age <= depth_of(d) - 1);
  endfunction

  function automatic bit m_id_stall(int d);
    return id_valid && (src_hazard(d, id_use_rs, id_rs) || src_hazard(d, id_use_rt, id_rt));
  endfunction

  function automatic bit m_issue(int d);
    return id_valid && !m_id_stall(d);
  endfunction

  function automatic bit m_if_stall(int d);
    return m_id_stall(d) || (m_issue(d) && id_is_branch) || ((cyc - last_br[d]) < BR_PEN);
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          last_wr[d][r] <= -100;
          last_ld[d][r] <= 1'b0;
        end
        last_br[d] <= -100;
        cnt[d]     <= 0;
      end else begin
        if (m_issue(d) && id_reg_wr && id_rd != 5'd0) begin
          last_wr[d][id_rd] <= cyc;
          last_ld[d][id_rd] <= id_is_load;
        end
        if (m_issue(d) && id_is_branch) last_br[d] <= cyc;
        if (m_id_stall(d) && cnt[d] < CNT_MAX) cnt[d] <= cnt[d] + 1;
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("dut%0d id_stall cyc %0d", d, cyc), id_stall_v[d], m_id_stall(d));
        chk($sformatf("dut%0d ex_bubble cyc %0d", d, cyc), ex_bubble_v[d], !m_issue(d));
        chk($sformatf("dut%0d if_stall cyc %0d", d, cyc), if_stall_v[d], m_if_stall(d));
        chk($sformatf("dut%0d stall_cnt cyc %0d", d, cyc), stall_cnt_v[d], cnt[d]);
      end
    end
  end

  task automatic set_instr(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                           input int rd, input bit wr, input bit ld, input bit br);
    id_valid = v; id_rs = 5'(rs); id_use_rs = urs; id_rt = 5'(rt); id_use_rt = urt;
    id_rd = 5'(rd); id_reg_wr = wr; id_is_load = ld; id_is_branch = br;
  endtask

  task automatic idle();
    set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state and a dependent ALU pair on the no-forwarding build.
    do_reset();
    mid();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst dut%0d if_stall", d), if_stall_v[d], 0);
      chk($sformatf("rst dut%0d id_stall", d), id_stall_v[d], 0);
      chk($sformatf("rst dut%0d ex_bubble", d), ex_bubble_v[d], 1);
      chk($sformatf("rst dut%0d stall_cnt", d), stall_cnt_v[d], 0);
    end
    next_cycle();
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0);
    mid(); chk("t1 add stall", id_stall_v[0], 0); chk("t1 add bubble", ex_bubble_v[0], 0);
    next_cycle();
    set_instr(1, 3, 1, 1, 1, 4, 1, 0, 0);
    mid(); chk("t1 sub stall1", id_stall_v[0], 1); chk("t1 sub bubble1", ex_bubble_v[0], 1);
    chk("t1 fwd sub stall", id_stall_v[1], 0);
    next_cycle();
    mid(); chk("t1 sub stall2", id_stall_v[0], 1); chk("t1 sub bubble2", ex_bubble_v[0], 1);
    chk("t1 sub if_stall2", if_stall_v[0], 1);
    next_cycle();
    mid(); chk("t1 sub issue", id_stall_v[0], 0); chk("t1 sub issue bubble", ex_bubble_v[0], 0);
    next_cycle();
    idle();
    mid(); chk("t1 stall_cnt", stall_cnt_v[0], 2); chk("t1 fwd stall_cnt", stall_cnt_v[1], 0);

    // Load-use versus ALU-use on the forwarding build.
    do_reset();
    set_instr(1, 1, 1, 0, 0, 5, 1, 1, 0);
    mid(); chk("t2 lw stall", id_stall_v[1], 0);
    next_cycle();
    set_instr(1, 5, 1, 1, 1, 6, 1, 0, 0);
    mid(); chk("t2 use stall", id_stall_v[1], 1); chk("t2 use bubble", ex_bubble_v[1], 1);
    next_cycle();
    mid(); chk("t2 use issue", id_stall_v[1], 0);
    next_cycle();
    set_instr(1, 1, 1, 2, 1, 5, 1, 0, 0);
    next_cycle();
    set_instr(1, 5, 1, 1, 1, 6, 1, 0, 0);
    mid(); chk("t2 alu use stall", id_stall_v[1], 0);
    next_cycle();
    idle();
    mid(); chk("t2 stall_cnt", stall_cnt_v[1], 1);

    // r0 writes and an unused rt never stall.
    do_reset();
    set_instr(1, 1, 1, 2, 1, 0, 1, 0, 0);
    next_cycle();
    set_instr(1, 0, 1, 0, 1, 9, 1, 0, 0);
    mid(); chk("t3 r0 stall", id_stall_v[0], 0);
    next_cycle();
    set_instr(1, 1, 1, 2, 1, 7, 1, 0, 0);
    next_cycle();
    set_instr(1, 1, 1, 7, 0, 8, 1, 0, 0);
    mid(); chk("t3 unused rt stall", id_stall_v[0], 0);
    next_cycle();

    // Branch freeze with no hazard.
    do_reset();
    set_instr(1, 1, 1, 2, 1, 0, 0, 0, 1);
    mid(); chk("t4 br if_stall0", if_stall_v[0], 1); chk("t4 br id_stall", id_stall_v[0], 0);
    next_cycle();
    idle();
    mid(); chk("t4 br if_stall1", if_stall_v[0], 1);
    next_cycle();
    mid(); chk("t4 br if_stall2", if_stall_v[0], 0);

    // Branch held by a load-use hazard starts its freeze only when it issues.
    do_reset();
    set_instr(1, 1, 1, 0, 0, 5, 1, 1, 0);
    next_cycle();
    set_instr(1, 5, 1, 0, 1, 0, 0, 0, 1);
    mid(); chk("t5 held id_stall", id_stall_v[1], 1); chk("t5 held if_stall", if_stall_v[1], 1);
    next_cycle();
    mid(); chk("t5 issue id_stall", id_stall_v[1], 0); chk("t5 issue if_stall", if_stall_v[1], 1);
    next_cycle();
    idle();
    mid(); chk("t5 freeze if_stall", if_stall_v[1], 1);
    next_cycle();
    mid(); chk("t5 done if_stall", if_stall_v[1], 0);

    // Reset in the middle of a stall clears everything.
    do_reset();
    set_instr(1, 1, 1, 2, 1, 3, 1, 0, 0);
    next_cycle();
    set_instr(1, 3, 1, 1, 1, 4, 1, 0, 0);
    mid(); chk("t6 pre stall", id_stall_v[0], 1);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    mid();
    chk("t6 post id_stall", id_stall_v[0], 0);
    chk("t6 post if_stall", if_stall_v[0], 0);
    chk("t6 post stall_cnt", stall_cnt_v[0], 0);
    next_cycle();

    // Back-to-back r3 chain: 20 stall cycles in 30 saturate a 4-bit counter.
    do_reset();
    set_instr(1, 3, 1, 1, 1, 3, 1, 0, 0);
    repeat (30) next_cycle();
    idle();
    mid(); chk("t7 saturated", stall_cnt_v[0], CNT_MAX); chk("t7 fwd cnt", stall_cnt_v[1], 0);
    next_cycle();

    // Random traffic over a small register window, with occasional resets.
    do_reset();
    repeat (3000) begin
      reset = ($urandom_range(0, 199) == 0);
      set_instr($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
      next_cycle();
    end
    reset = 1'b0;
    idle();
    next_cycle();
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
